// File: rtl/tl_pkg.sv
// Shared traffic-light encodings: lamp codes, fault causes and monitor states.
package tl_pkg;

  localparam int unsigned LAMP_W  = 2;
  localparam int unsigned FCODE_W = 3;

  localparam logic [LAMP_W-1:0] LAMP_RED     = 2'b00;
  localparam logic [LAMP_W-1:0] LAMP_YELLOW  = 2'b01;
  localparam logic [LAMP_W-1:0] LAMP_GREEN   = 2'b10;
  localparam logic [LAMP_W-1:0] LAMP_INVALID = 2'b11;

  localparam logic [FCODE_W-1:0] FC_NONE      = 3'd0;
  localparam logic [FCODE_W-1:0] FC_INVALID   = 3'd1;
  localparam logic [FCODE_W-1:0] FC_CONFLICT  = 3'd2;
  localparam logic [FCODE_W-1:0] FC_BAD_SEQ   = 3'd3;
  localparam logic [FCODE_W-1:0] FC_SHORT_YEL = 3'd4;
  localparam logic [FCODE_W-1:0] FC_WATCHDOG  = 3'd5;

  typedef enum logic {
    ST_MONITOR = 1'b0,
    ST_FAULT   = 1'b1
  } mon_state_e;

  // Legal lamp steps: hold, RED->GREEN, GREEN->YELLOW, YELLOW->RED.
  function automatic logic lamp_step_ok(input logic [LAMP_W-1:0] prev,
                                        input logic [LAMP_W-1:0] cur);
    logic ok;
    ok = (prev == cur) ||
         (prev == LAMP_RED    && cur == LAMP_GREEN)  ||
         (prev == LAMP_GREEN  && cur == LAMP_YELLOW) ||
         (prev == LAMP_YELLOW && cur == LAMP_RED);
    return ok;
  endfunction

endpackage

// File: rtl/approach_checker.sv
// Per-approach sequence checker: tracks the previous lamp code and yellow
// duration, flags illegal transitions and yellows that end too early.
module approach_checker
  import tl_pkg::*;
#(
  parameter int unsigned MIN_YELLOW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [LAMP_W-1:0] code,
  output logic [LAMP_W-1:0] prev,
  output logic              bad_seq_c,
  output logic              short_yel_c
);

  localparam int unsigned YEL_W = (MIN_YELLOW > 0) ? $clog2(MIN_YELLOW + 1) : 1;

  logic [YEL_W-1:0] yel_cnt;

  // Invalid codes are reported elsewhere, so they never count as a sequence break.
  always_comb begin
    bad_seq_c   = 1'b0;
    short_yel_c = 1'b0;
    if (code != LAMP_INVALID && prev != LAMP_INVALID)
      bad_seq_c = !lamp_step_ok(prev, code);
    if (prev == LAMP_YELLOW && code == LAMP_RED)
      short_yel_c = (yel_cnt < YEL_W'(MIN_YELLOW));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev    <= LAMP_RED;
      yel_cnt <= '0;
    end else if (clr) begin
      prev    <= LAMP_RED;
      yel_cnt <= '0;
    end else if (en) begin
      prev <= code;
      if (code != LAMP_YELLOW)
        yel_cnt <= '0;
      else if (yel_cnt < YEL_W'(MIN_YELLOW))
        yel_cnt <= yel_cnt + YEL_W'(1);
    end
  end

endmodule

// File: rtl/signal_conflict_monitor.sv
// Safety monitor on the controller lamp outputs: latches the first violation
// and requests flash mode until acknowledged with both approaches red.
module signal_conflict_monitor
  import tl_pkg::*;
#(
  parameter int unsigned MIN_YELLOW = 3,
  parameter int unsigned WDT_CYCLES = 64,
  parameter int unsigned FLASH_HALF = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] hwy,
  input  logic [1:0] cny,
  input  logic       ack,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash
);

  localparam int unsigned WDT_W   = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;
  localparam int unsigned FLASH_W = (FLASH_HALF > 2) ? $clog2(FLASH_HALF) : 1;

  mon_state_e         state_q, state_d;
  logic [FCODE_W-1:0] code_q, code_d;
  logic               flash_q, flash_d;
  logic [FLASH_W-1:0] fcnt_q, fcnt_d;
  logic [WDT_W-1:0]   wdt_q, wdt_d;

  logic [LAMP_W-1:0]  hwy_prev, cny_prev;
  logic               hwy_bad_c, cny_bad_c, hwy_short_c, cny_short_c;
  logic               mon_en_c, clr_c;
  logic               invalid_c, conflict_c, changed_c, wdt_hit_c;
  logic               viol_c;
  logic [FCODE_W-1:0] viol_code_c;

  approach_checker #(.MIN_YELLOW(MIN_YELLOW)) u_hwy (
    .clk        (clk),
    .rst_n      (reset),
    .en         (mon_en_c),
    .clr        (clr_c),
    .code       (hwy),
    .prev       (hwy_prev),
    .bad_seq_c  (hwy_bad_c),
    .short_yel_c(hwy_short_c)
  );

  approach_checker #(.MIN_YELLOW(MIN_YELLOW)) u_cny (
    .clk        (clk),
    .rst_n      (reset),
    .en         (mon_en_c),
    .clr        (clr_c),
    .code       (cny),
    .prev       (cny_prev),
    .bad_seq_c  (cny_bad_c),
    .short_yel_c(cny_short_c)
  );

  // Violation detection with fixed priority; lowest fault code wins.
  always_comb begin
    invalid_c  = (hwy == LAMP_INVALID) || (cny == LAMP_INVALID);
    conflict_c = (hwy != LAMP_RED) && (cny != LAMP_RED);
    changed_c  = ({hwy, cny} != {hwy_prev, cny_prev});
    wdt_hit_c  = (WDT_CYCLES != 0) && !changed_c &&
                 (wdt_q == WDT_W'(WDT_CYCLES - 1));
    viol_c      = 1'b1;
    viol_code_c = FC_NONE;
    if (invalid_c)                     viol_code_c = FC_INVALID;
    else if (conflict_c)               viol_code_c = FC_CONFLICT;
    else if (hwy_bad_c || cny_bad_c)   viol_code_c = FC_BAD_SEQ;
    else if (hwy_short_c || cny_short_c) viol_code_c = FC_SHORT_YEL;
    else if (wdt_hit_c)                viol_code_c = FC_WATCHDOG;
    else                               viol_c = 1'b0;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    flash_d  = flash_q;
    fcnt_d   = fcnt_q;
    wdt_d    = wdt_q;
    mon_en_c = 1'b0;
    clr_c    = 1'b0;
    case (state_q)
      ST_MONITOR: begin
        mon_en_c = 1'b1;
        wdt_d    = changed_c ? '0 : wdt_q + WDT_W'(1);
        if (viol_c) begin
          state_d = ST_FAULT;
          code_d  = viol_code_c;
          flash_d = 1'b0;
          // Preloaded so the first cycle in fault turns the flash on.
          fcnt_d  = FLASH_W'(FLASH_HALF - 1);
        end
      end
      ST_FAULT: begin
        if (ack && hwy == LAMP_RED && cny == LAMP_RED) begin
          state_d = ST_MONITOR;
          code_d  = FC_NONE;
          flash_d = 1'b0;
          fcnt_d  = '0;
          wdt_d   = '0;
          clr_c   = 1'b1;
        end else if (fcnt_q == FLASH_W'(FLASH_HALF - 1)) begin
          flash_d = !flash_q;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + FLASH_W'(1);
        end
      end
      default: state_d = ST_MONITOR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_MONITOR;
      code_q  <= FC_NONE;
      flash_q <= 1'b0;
      fcnt_q  <= '0;
      wdt_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      flash_q <= flash_d;
      fcnt_q  <= fcnt_d;
      wdt_q   <= wdt_d;
    end
  end

  assign fault      = (state_q == ST_FAULT);
  assign fault_code = code_q;
  assign flash      = flash_q;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Directed bench for signal_conflict_monitor; a second instance has the watchdog disabled.
module tb_signal_conflict_monitor;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] G = 2'b10;
  localparam logic [1:0] X = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] hwy = R;
  logic [1:0] cny = R;
  logic       ack = 1'b0;
  logic       fault, fault0, flash, flash0;
  logic [2:0] fault_code, fault_code0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  signal_conflict_monitor dut (
    .clk(clk), .reset(reset), .hwy(hwy), .cny(cny), .ack(ack),
    .fault(fault), .fault_code(fault_code), .flash(flash)
  );

  signal_conflict_monitor #(.WDT_CYCLES(0)) dut_nowdt (
    .clk(clk), .reset(reset), .hwy(hwy), .cny(cny), .ack(ack),
    .fault(fault0), .fault_code(fault_code0), .flash(flash0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] h, input logic [1:0] c);
    hwy = h;
    cny = c;
  endtask

  // Reset is released 1 ns after an edge, leaving inputs at RED/RED.
  task automatic do_reset();
    reset = 1'b0;
    ack   = 1'b0;
    drive(R, R);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic any_fault, any_flash;
    logic [2:0] any_code;

    // Reset state
    do_reset();
    check("rst_fault", fault, 0);
    check("rst_code", fault_code, 0);
    check("rst_flash", flash, 0);

    // Legal cycle, three rounds
    any_fault = 0; any_flash = 0; any_code = 0;
    for (int r = 0; r < 3; r++) begin
      drive(G, R);
      repeat (10) begin step(); any_fault |= fault; any_flash |= flash; any_code |= fault_code; end
      drive(Y, R);
      repeat (3)  begin step(); any_fault |= fault; any_flash |= flash; any_code |= fault_code; end
      drive(R, G);
      repeat (10) begin step(); any_fault |= fault; any_flash |= flash; any_code |= fault_code; end
      drive(R, Y);
      repeat (3)  begin step(); any_fault |= fault; any_flash |= flash; any_code |= fault_code; end
      drive(R, R);
      step(); any_fault |= fault; any_flash |= flash; any_code |= fault_code;
    end
    check("legal_fault", any_fault, 0);
    check("legal_code", any_code, 0);
    check("legal_flash", any_flash, 0);

    // Conflict, flash cadence, ack handling
    do_reset();
    drive(G, R); step();
    check("pre_conflict_fault", fault, 0);
    drive(G, G); step();
    check("conflict_fault", fault, 1);
    check("conflict_code", fault_code, 2);
    check("conflict_flash_k", flash, 0);
    step();
    check("flash_k1", flash, 1);
    repeat (3) step();
    check("flash_k4", flash, 1);
    step();
    check("flash_k5", flash, 0);
    repeat (3) step();
    check("flash_k8", flash, 0);
    step();
    check("flash_k9", flash, 1);
    ack = 1'b1; drive(G, R); step();
    check("ack_not_red_fault", fault, 1);
    check("ack_not_red_code", fault_code, 2);
    drive(R, R); step();
    check("ack_clr_fault", fault, 0);
    check("ack_clr_code", fault_code, 0);
    check("ack_clr_flash", flash, 0);
    ack = 1'b0;
    // Back in monitor after ack: a fresh violation is caught with its own code
    drive(Y, R); step();
    check("post_ack_badseq", fault_code, 3);

    // Short yellow
    do_reset();
    drive(G, R); step();
    drive(Y, R); step(); step();
    check("short_yel_pre", fault, 0);
    drive(R, R); step();
    check("short_yel_fault", fault, 1);
    check("short_yel_code", fault_code, 4);

    // Green straight to red
    do_reset();
    drive(G, R); step();
    drive(R, R); step();
    check("g2r_code", fault_code, 3);

    // Priority: invalid + conflict + cny YELLOW->GREEN break in one cycle
    do_reset();
    drive(R, G); step();
    drive(R, Y); step(); step(); step();
    check("prio_pre", fault, 0);
    drive(X, G); step();
    check("prio_code", fault_code, 1);
    drive(G, G); step();
    drive(Y, R); step();
    check("prio_hold_code", fault_code, 1);

    // Watchdog: first G sample is a change, fault on the 64th unchanged sample
    do_reset();
    drive(G, R);
    repeat (64) step();
    check("wdt_63_unchanged", fault, 0);
    step();
    check("wdt_fault", fault, 1);
    check("wdt_code", fault_code, 5);
    repeat (135) step();
    check("nowdt_fault", fault0, 0);
    check("nowdt_code", fault_code0, 0);

    // Async reset mid-fault clears outputs before the next edge
    do_reset();
    drive(G, R); step();
    drive(X, R); step();
    check("async_pre_fault", fault, 1);
    check("async_pre_code", fault_code, 1);
    #2 reset = 1'b0;
    #1;
    check("async_fault", fault, 0);
    check("async_code", fault_code, 0);
    check("async_flash", flash, 0);
    do_reset();
    check("async_release_fault", fault, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
